// File: rtl/sio_device_if.sv
// Local and line-side signal bundle of the SIO device.
// master = device side, slave = host/IOBUF side.
interface sio_device_if #(
  parameter int NBT = 40,
  parameter int NBR = 32
);
  logic           sdio_i;
  logic           sdio_o;
  logic           sdio_t;
  logic           cmd_valid;
  logic [NBT-1:0] cmd_data;
  logic           rd_req;
  logic           rd_ack;
  logic [NBR-1:0] rd_data;
  logic           err;

  modport master (
    input  sdio_i, rd_ack, rd_data,
    output sdio_o, sdio_t, cmd_valid, cmd_data, rd_req, err
  );

  modport slave (
    output sdio_i, rd_ack, rd_data,
    input  sdio_o, sdio_t, cmd_valid, cmd_data, rd_req, err
  );
endinterface

// File: rtl/sio_device.sv
// Device end of the single-wire SIO link: frame decode and read response.
// Define SIO_DEVICE_SYNC_EN for a 2-flop synchroniser plus majority filter.
module sio_device #(
  parameter int NBT  = 40,
  parameter int NBR  = 32,
  parameter int OSR  = 4,
  parameter int TURN = 14
) (
  input  logic       c,
  input  logic       rst_n,
  sio_device_if.master bus
);
  typedef enum logic [2:0] {
    ARM, IDLE, START, DATA, STOP, TURNW, RESP, TAIL
  } state_t;

  localparam int OCW = $clog2(OSR*TURN+1);
  localparam int BMX = (NBT > NBR) ? NBT : NBR;
  localparam int BCW = $clog2(BMX+1);
  localparam logic [OCW-1:0] OC_BIT  = OCW'(OSR-1);
  localparam logic [OCW-1:0] OC_MID  = OCW'(OSR/2-1);
  localparam logic [OCW-1:0] OC_TURN = OCW'(OSR*TURN);
  localparam logic [OCW-1:0] OC_ONE  = OCW'(1);
  localparam logic [BCW-1:0] BC_TL   = BCW'(NBT-1);
  localparam logic [BCW-1:0] BC_R    = BCW'(NBR);

  logic s;

`ifdef SIO_DEVICE_SYNC_EN
  logic [1:0] sy;
  logic [1:0] h;
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      sy <= 2'b11;
      h  <= 2'b11;
      s  <= 1'b1;
    end else begin
      sy <= {sy[0], bus.sdio_i};
      h  <= {h[0], sy[1]};
      s  <= (sy[1] & h[0]) | (sy[1] & h[1]) | (h[0] & h[1]);
    end
  end
`else
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) s <= 1'b1;
    else        s <= bus.sdio_i;
  end
`endif

  state_t         state, state_d;
  logic [OCW-1:0] oc, oc_d;
  logic [BCW-1:0] bc, bc_d;
  logic [NBT-1:0] frm, frm_d;
  logic [NBR-1:0] sh, sh_d;
  logic           got, got_d;
  logic           cv_q, cv_d;
  logic [NBT-1:0] cd_q, cd_d;
  logic           rq_q, rq_d;
  logic           er_q, er_d;
  logic           o_q, o_d;
  logic           t_q, t_d;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARM;
      oc    <= '0;
      bc    <= '0;
      frm   <= '0;
      sh    <= '0;
      got   <= 1'b0;
      cv_q  <= 1'b0;
      cd_q  <= '0;
      rq_q  <= 1'b0;
      er_q  <= 1'b0;
      o_q   <= 1'b1;
      t_q   <= 1'b1;
    end else begin
      state <= state_d;
      oc    <= oc_d;
      bc    <= bc_d;
      frm   <= frm_d;
      sh    <= sh_d;
      got   <= got_d;
      cv_q  <= cv_d;
      cd_q  <= cd_d;
      rq_q  <= rq_d;
      er_q  <= er_d;
      o_q   <= o_d;
      t_q   <= t_d;
    end
  end

  always_comb begin
    state_d = state;
    oc_d    = oc;
    bc_d    = bc;
    frm_d   = frm;
    sh_d    = sh;
    got_d   = got;
    cv_d    = 1'b0;
    er_d    = 1'b0;
    cd_d    = cd_q;
    rq_d    = rq_q;
    o_d     = o_q;
    t_d     = t_q;
    unique case (state)
      ARM: begin
        if (!s) begin
          oc_d = '0;
        end else if (oc == OC_BIT) begin
          state_d = IDLE;
          oc_d    = '0;
        end else begin
          oc_d = oc + 1'b1;
        end
      end
      IDLE: begin
        if (!s) begin
          state_d = START;
          oc_d    = '0;
        end
      end
      START: begin
        if (oc != OC_MID) begin
          oc_d = oc + 1'b1;
        end else if (s) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          oc_d    = '0;
          bc_d    = '0;
        end
      end
      DATA: begin
        if (oc == OC_BIT) begin
          oc_d  = '0;
          frm_d = {frm[NBT-2:0], s};
          bc_d  = bc + 1'b1;
          if (bc == BC_TL) state_d = STOP;
        end else begin
          oc_d = oc + 1'b1;
        end
      end
      STOP: begin
        if (oc != OC_BIT) begin
          oc_d = oc + 1'b1;
        end else if (!s) begin
          er_d    = 1'b1;
          state_d = ARM;
          oc_d    = '0;
        end else begin
          cv_d = 1'b1;
          cd_d = frm;
          if (frm[NBT-1]) begin
            rq_d    = 1'b1;
            got_d   = 1'b0;
            oc_d    = OC_ONE;
            state_d = TURNW;
          end else begin
            state_d = IDLE;
            oc_d    = '0;
          end
        end
      end
      TURNW: begin
        if (bus.rd_ack && !got) begin
          sh_d  = bus.rd_data;
          got_d = 1'b1;
          rq_d  = 1'b0;
        end
        if (oc == OC_TURN) begin
          rq_d = 1'b0;
          oc_d = '0;
          if (got_d) begin
            state_d = RESP;
            t_d     = 1'b0;
            o_d     = 1'b0;
            bc_d    = '0;
          end else begin
            state_d = ARM;
            er_d    = 1'b1;
          end
        end else begin
          oc_d = oc + 1'b1;
        end
      end
      RESP: begin
        if (oc != OC_BIT) begin
          oc_d = oc + 1'b1;
        end else if (bc == BC_R) begin
          oc_d    = '0;
          state_d = TAIL;
          o_d     = 1'b1;
        end else begin
          oc_d = '0;
          o_d  = sh[NBR-1];
          sh_d = {sh[NBR-2:0], 1'b0};
          bc_d = bc + 1'b1;
        end
      end
      TAIL: begin
        if (oc == OC_BIT) begin
          state_d = ARM;
          oc_d    = '0;
          t_d     = 1'b1;
          o_d     = 1'b1;
        end else begin
          oc_d = oc + 1'b1;
        end
      end
      default: state_d = ARM;
    endcase
  end

  assign bus.sdio_o    = o_q;
  assign bus.sdio_t    = t_q;
  assign bus.cmd_valid = cv_q;
  assign bus.cmd_data  = cd_q;
  assign bus.rd_req    = rq_q;
  assign bus.err       = er_q;
endmodule

// File: tb/tb_sio_device.sv
// Directed bench for sio_device: write, read, glitch, framing error,
// read timeout and reset during a response.
module tb_sio_device;
  localparam int NBT  = 40;
  localparam int NBR  = 32;
  localparam int OSR  = 4;
  localparam int TURN = 14;

  logic c = 1'b0;
  logic rst_n = 1'b0;
  logic line = 1'b1;
  always #5 c = ~c;

  sio_device_if #(.NBT(NBT), .NBR(NBR)) bus();
  assign bus.sdio_i = line;

  sio_device #(
    .NBT(NBT), .NBR(NBR), .OSR(OSR), .TURN(TURN)
  ) dut (
    .c(c),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge c) cyc <= cyc + 1;

  int cv_n, er_n, drv_n, first_low, cv_cyc, er_cyc;
  logic lg [0:255];

  always @(negedge c) begin
    if (rst_n) begin
      if (bus.cmd_valid) begin
        cv_n++;
        cv_cyc = cyc;
      end
      if (bus.err) begin
        er_n++;
        er_cyc = cyc;
      end
      if (!bus.sdio_t) begin
        if (drv_n == 0) first_low = cyc;
        if (drv_n < 256) lg[drv_n] = bus.sdio_o;
        drv_n++;
      end
    end
  end

  task automatic clr();
    cv_n = 0;
    er_n = 0;
    drv_n = 0;
    first_low = -1;
    cv_cyc = -1;
    er_cyc = -1;
  endtask

  // e = edge count at which the device takes its stop-bit sample
  task automatic send_frame(input logic [NBT-1:0] d,
                            input logic stopb, output int e);
    @(posedge c); #1;
    e = cyc + 4 + OSR*(NBT+1);
    line = 1'b0;
    repeat (OSR) @(posedge c);
    #1;
    for (int i = NBT-1; i >= 0; i--) begin
      line = d[i];
      repeat (OSR) @(posedge c);
      #1;
    end
    line = stopb;
    repeat (OSR) @(posedge c);
    #1;
  endtask

  task automatic test_reset();
    bus.rd_ack = 1'b0;
    bus.rd_data = '0;
    rst_n = 1'b0;
    #12;
    tests++;
    if (bus.sdio_t !== 1'b1) begin
      fails++; $display("FAIL rst_sdio_t got %b want 1", bus.sdio_t);
    end
    tests++;
    if (bus.sdio_o !== 1'b1) begin
      fails++; $display("FAIL rst_sdio_o got %b want 1", bus.sdio_o);
    end
    tests++;
    if (bus.cmd_valid !== 1'b0 || bus.rd_req !== 1'b0 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL rst_pulses got cv=%b rq=%b err=%b want 0",
               bus.cmd_valid, bus.rd_req, bus.err);
    end
    tests++;
    if (bus.cmd_data !== 40'h0) begin
      fails++; $display("FAIL rst_cmd_data got %h want 0", bus.cmd_data);
    end
    @(negedge c);
    rst_n = 1'b1;
    repeat (10) @(posedge c);
  endtask

  task automatic test_write();
    int e;
    clr();
    send_frame(40'h12_3456_789A, 1'b1, e);
    repeat (10) @(negedge c);
    tests++;
    if (cv_n !== 1 || cv_cyc !== e) begin
      fails++;
      $display("FAIL wr_cmd_valid got n=%0d at %0d want 1 at %0d", cv_n, cv_cyc, e);
    end
    tests++;
    if (bus.cmd_data !== 40'h12_3456_789A) begin
      fails++; $display("FAIL wr_cmd_data got %h want 123456789a", bus.cmd_data);
    end
    tests++;
    if (bus.rd_req !== 1'b0 || drv_n !== 0 || er_n !== 0) begin
      fails++;
      $display("FAIL wr_side got rq=%b drv=%0d err=%0d want 0 0 0",
               bus.rd_req, drv_n, er_n);
    end
  endtask

  task automatic test_glitch();
    int e;
    clr();
    @(posedge c); #1 line = 1'b0;
    @(posedge c); #1 line = 1'b1;
    repeat (20) @(negedge c);
    tests++;
    if (cv_n !== 0 || er_n !== 0) begin
      fails++; $display("FAIL glitch got cv=%0d err=%0d want 0 0", cv_n, er_n);
    end
    send_frame(40'h0F_F0F0_0F0F, 1'b1, e);
    repeat (4) @(negedge c);
    tests++;
    if (cv_n !== 1 || bus.cmd_data !== 40'h0F_F0F0_0F0F) begin
      fails++;
      $display("FAIL glitch_next got n=%0d %h want 1 0ff0f00f0f", cv_n, bus.cmd_data);
    end
  endtask

  task automatic test_stop_err();
    int e;
    clr();
    send_frame(40'h55_AA55_AA55, 1'b0, e);
    line = 1'b1;
    repeat (3) @(posedge c);
    #1 line = 1'b0;
    repeat (8) @(posedge c);
    #1 line = 1'b1;
    repeat (200) @(negedge c);
    tests++;
    if (er_n !== 1 || er_cyc !== e) begin
      fails++;
      $display("FAIL stop_err got n=%0d at %0d want 1 at %0d", er_n, er_cyc, e);
    end
    tests++;
    if (cv_n !== 0 || bus.cmd_data !== 40'h0F_F0F0_0F0F) begin
      fails++;
      $display("FAIL stop_err_cmd got n=%0d %h want 0 0ff0f00f0f", cv_n, bus.cmd_data);
    end
  endtask

  task automatic test_read();
    int e;
    logic [31:0] w;
    clr();
    send_frame(40'h80_0000_0010, 1'b1, e);
    tests++;
    if (bus.rd_req !== 1'b1) begin
      fails++; $display("FAIL rd_req_rise got %b want 1", bus.rd_req);
    end
    repeat (5) @(posedge c);
    #1;
    bus.rd_ack = 1'b1;
    bus.rd_data = 32'hCAFE_F00D;
    @(posedge c); #1;
    bus.rd_ack = 1'b0;
    bus.rd_data = '0;
    tests++;
    if (bus.rd_req !== 1'b0) begin
      fails++; $display("FAIL rd_req_drop got %b want 0", bus.rd_req);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge c);
      if (drv_n > 0 && bus.sdio_t) break;
    end
    tests++;
    if (cv_n !== 1 || bus.cmd_data !== 40'h80_0000_0010) begin
      fails++;
      $display("FAIL rd_cmd got n=%0d %h want 1 8000000010", cv_n, bus.cmd_data);
    end
    tests++;
    if (first_low !== e + 56) begin
      fails++; $display("FAIL rd_turn got %0d want %0d", first_low - e, 56);
    end
    tests++;
    if (drv_n !== 136) begin
      fails++; $display("FAIL rd_driven got %0d want 136", drv_n);
    end
    for (int k = 0; k < 32; k++) w[31-k] = lg[6 + 4*k];
    tests++;
    if (lg[2] !== 1'b0 || lg[134] !== 1'b1) begin
      fails++; $display("FAIL rd_frame got start=%b tail=%b want 0 1", lg[2], lg[134]);
    end
    tests++;
    if (w !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL rd_word got %h want cafef00d", w);
    end
    tests++;
    if (er_n !== 0) begin
      fails++; $display("FAIL rd_err got %0d want 0", er_n);
    end
  endtask

  task automatic test_timeout();
    int e;
    repeat (10) @(posedge c);
    clr();
    send_frame(40'hFF_0000_0001, 1'b1, e);
    for (int i = 0; i < 200 && cyc < e + 55; i++) @(negedge c);
    tests++;
    if (cyc !== e + 55 || bus.rd_req !== 1'b1) begin
      fails++; $display("FAIL to_hold got rq=%b at %0d want 1 at %0d", bus.rd_req, cyc, e + 55);
    end
    @(negedge c);
    tests++;
    if (bus.rd_req !== 1'b0 || bus.err !== 1'b1) begin
      fails++; $display("FAIL to_expire got rq=%b err=%b want 0 1", bus.rd_req, bus.err);
    end
    repeat (200) @(negedge c);
    tests++;
    if (drv_n !== 0 || er_n !== 1) begin
      fails++; $display("FAIL to_after got drv=%0d err=%0d want 0 1", drv_n, er_n);
    end
  endtask

  task automatic test_reset_mid_resp();
    int e;
    repeat (10) @(posedge c);
    clr();
    send_frame(40'h80_1234_5678, 1'b1, e);
    repeat (2) @(posedge c);
    #1;
    bus.rd_ack = 1'b1;
    bus.rd_data = 32'h0000_0000;
    @(posedge c); #1;
    bus.rd_ack = 1'b0;
    for (int i = 0; i < 200 && drv_n <= 20; i++) @(negedge c);
    rst_n = 1'b0;
    #1;
    tests++;
    if (drv_n <= 20 || bus.sdio_t !== 1'b1 || bus.sdio_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_resp got drv=%0d t=%b o=%b want >20 1 1",
               drv_n, bus.sdio_t, bus.sdio_o);
    end
    @(negedge c);
    rst_n = 1'b1;
    clr();
    repeat (10) @(posedge c);
    send_frame(40'h3C_A5A5_5A5A, 1'b1, e);
    repeat (4) @(negedge c);
    tests++;
    if (cv_n !== 1 || bus.cmd_data !== 40'h3C_A5A5_5A5A || drv_n !== 0) begin
      fails++;
      $display("FAIL rst_next got n=%0d %h drv=%0d want 1 3ca5a55a5a 0",
               cv_n, bus.cmd_data, drv_n);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_write();
    test_glitch();
    test_stop_err();
    test_read();
    test_timeout();
    test_reset_mid_resp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
